// File: rtl/and2_share_pkg.sv
// Shared definitions for the AND2 time-sharing arbiter: state encoding and parameter legality.
package and2_share_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EVAL = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      StIdle = ST_IDLE,
      StEval = ST_EVAL,
      StDone = ST_DONE
   } state_e;

   function automatic bit params_legal(input int unsigned n, input int unsigned settle_cyc);
      return (n >= 2) && (n <= 16) && (settle_cyc >= 1);
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request searching upward from ptr+1, modulo N.
module rr_pick #(
   parameter int unsigned N  = 4,
   parameter int unsigned PW = 2
) (
   input  logic [N-1:0]  req_i,
   input  logic [PW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic [PW-1:0] idx_o,
   output logic          valid_o
);

   int          cand;
   logic [PW-1:0] cidx;

   always_comb begin
      gnt_o   = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      cand    = 0;
      cidx    = '0;
      for (int i = 1; i <= int'(N); i++) begin
         cand = (int'(ptr_i) + i) % int'(N);
         cidx = PW'(cand);
         if (!valid_o && req_i[cidx]) begin
            valid_o     = 1'b1;
            idx_o       = cidx;
            gnt_o[cidx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/and2_share_arbiter.sv
// Round-robin arbiter time-sharing one external AND2 gate among N requesters.
module and2_share_arbiter
   import and2_share_pkg::*;
#(
   parameter int unsigned N          = 4,
   parameter int unsigned SETTLE_CYC = 1
) (
   input  logic         CLK,
   input  logic         RESET,
   input  logic [N-1:0] REQ,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   output logic [N-1:0] GNT,
   output logic [N-1:0] ACK,
   output logic         RES,
   output logic         BUSY,
   output logic         AND_I0,
   output logic         AND_I1,
   input  logic         AND_O
);

   localparam int unsigned PW = $clog2(N);
   localparam int unsigned CW = $clog2(SETTLE_CYC + 1);

   if (!params_legal(N, SETTLE_CYC)) begin : g_param_check
      $error("and2_share_arbiter: illegal N or SETTLE_CYC");
   end

   state_e        state_q;
   logic [N-1:0]  gnt_q, ack_q;
   logic          res_q, i0_q, i1_q;
   logic [PW-1:0] ptr_q;
   logic [CW-1:0] cnt_q;

   logic [N-1:0]  pick_gnt;
   logic [PW-1:0] pick_idx;
   logic          pick_valid;

   rr_pick #(
      .N  (N),
      .PW (PW)
   ) u_rr_pick (
      .req_i   (REQ),
      .ptr_i   (ptr_q),
      .gnt_o   (pick_gnt),
      .idx_o   (pick_idx),
      .valid_o (pick_valid)
   );

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= StIdle;
         gnt_q   <= '0;
         ack_q   <= '0;
         res_q   <= 1'b0;
         i0_q    <= 1'b0;
         i1_q    <= 1'b0;
         ptr_q   <= PW'(N - 1);
         cnt_q   <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (pick_valid) begin
                  // Operands are captured here; later changes on A/B/REQ are ignored.
                  gnt_q   <= pick_gnt;
                  i0_q    <= A[pick_idx];
                  i1_q    <= B[pick_idx];
                  ptr_q   <= pick_idx;
                  cnt_q   <= '0;
                  state_q <= StEval;
               end else begin
                  i0_q <= 1'b0;
                  i1_q <= 1'b0;
               end
            end
            StEval: begin
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CW'(SETTLE_CYC - 1)) begin
                  res_q   <= AND_O;
                  ack_q   <= gnt_q;
                  state_q <= StDone;
               end
            end
            StDone: begin
               ack_q   <= '0;
               gnt_q   <= '0;
               i0_q    <= 1'b0;
               i1_q    <= 1'b0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign GNT    = gnt_q;
   assign ACK    = ack_q;
   assign RES    = res_q;
   assign BUSY   = (state_q != StIdle);
   assign AND_I0 = i0_q;
   assign AND_I1 = i1_q;

endmodule

// File: tb/tb_and2_share_arbiter.sv
// Scoreboard bench: one arbiter with a direct AND2, one with SETTLE_CYC=3 and a slow gate.
module tb_and2_share_arbiter;

   typedef struct packed {
      logic [3:0] ack;
      logic       res;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req, a, b, gnt, ack;
   logic       res, busy, i0, i1, o;
   logic [3:0] req3, a3, b3, gnt3, ack3;
   logic       res3, busy3, i0_3, i1_3, o3, d1_3, d2_3;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   exp_t q0[$];
   exp_t q3[$];

   always #5 clk = ~clk;

   // Shared gate next to each arbiter; the second one settles over two cycles.
   assign o = i0 & i1;
   always @(posedge clk) begin
      d1_3 <= i0_3 & i1_3;
      d2_3 <= d1_3;
   end
   assign o3 = d2_3;

   and2_share_arbiter #(.N(4), .SETTLE_CYC(1)) u_dut (
      .CLK(clk), .RESET(rst), .REQ(req), .A(a), .B(b), .GNT(gnt), .ACK(ack), .RES(res),
      .BUSY(busy), .AND_I0(i0), .AND_I1(i1), .AND_O(o)
   );

   and2_share_arbiter #(.N(4), .SETTLE_CYC(3)) u_dut3 (
      .CLK(clk), .RESET(rst), .REQ(req3), .A(a3), .B(b3), .GNT(gnt3), .ACK(ack3), .RES(res3),
      .BUSY(busy3), .AND_I0(i0_3), .AND_I1(i1_3), .AND_O(o3)
   );

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   // Waits for an ACK on the chosen instance, then pops and compares the scoreboard.
   task automatic wait_ack(input bit sel, input int budget, output int lat);
      exp_t       e;
      logic [3:0] ak;
      logic       rs;
      bit         got;
      got = 1'b0;
      lat = 0;
      ak  = '0;
      rs  = 1'b0;
      for (int i = 1; i <= budget && !got; i++) begin
         tick();
         ak = sel ? ack3 : ack;
         rs = sel ? res3 : res;
         if (ak != 4'b0) begin
            got = 1'b1;
            lat = i;
         end
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL ack_timeout dut%0d: no ACK within %0d cycles", sel ? 3 : 1, budget);
      end else if ((sel ? q3.size() : q0.size()) == 0) begin
         errors++;
         $display("FAIL unexpected_ack dut%0d: got ack=%b res=%b, none expected",
                  sel ? 3 : 1, ak, rs);
      end else begin
         e = sel ? q3.pop_front() : q0.pop_front();
         if ({ak, rs} !== {e.ack, e.res}) begin
            errors++;
            $display("FAIL ack_result dut%0d: got ack=%b res=%b, expected ack=%b res=%b",
                     sel ? 3 : 1, ak, rs, e.ack, e.res);
         end
      end
   endtask

   task automatic test_reset();
      int lat;
      rst = 1'b1;
      req = '0; a = '0; b = '0;
      req3 = '0; a3 = '0; b3 = '0;
      repeat (2) tick();
      checks++;
      if ({gnt, ack, res, busy, i0, i1} !== 12'b0) begin
         errors++;
         $display("FAIL reset_state: got %b, expected all zero", {gnt, ack, res, busy, i0, i1});
      end
      rst = 1'b0;
      a = 4'b1111; b = 4'b0001; req = 4'b1111;
      tick();
      checks++;
      if (gnt !== 4'b0001) begin
         errors++;
         $display("FAIL first_grant: got gnt=%b, expected 0001", gnt);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({gnt, ack, res, busy, i0, i1} !== 12'b0) begin
         errors++;
         $display("FAIL abort_outputs: got %b, expected all zero", {gnt, ack, res, busy, i0, i1});
      end
      tick();
      checks++;
      if (ack !== 4'b0) begin
         errors++;
         $display("FAIL abort_no_ack: got ack=%b, expected 0000", ack);
      end
      rst = 1'b0;
      tick();
      checks++;
      if (gnt !== 4'b0001) begin
         errors++;
         $display("FAIL grant_after_reset: got gnt=%b, expected 0001", gnt);
      end
      req = '0;
      q0.push_back('{ack: 4'b0001, res: a[0] & b[0]});
      wait_ack(1'b0, 4, lat);
      tick();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_return_idle: got busy=%b, expected 0", busy);
      end
   endtask

   task automatic test_single();
      int lat;
      for (int r = 0; r < 2; r++) begin
         req = 4'b0010; a = 4'b0010;
         b = (r == 0) ? 4'b0010 : 4'b0000;
         tick();
         checks++;
         if ({gnt, i0, i1} !== {4'b0010, 1'b1, b[1]}) begin
            errors++;
            $display("FAIL single_grant[%0d]: got gnt=%b i0=%b i1=%b, expected 0010 1 %b",
                     r, gnt, i0, i1, b[1]);
         end
         q0.push_back('{ack: 4'b0010, res: (r == 0)});
         wait_ack(1'b0, 4, lat);
         req = '0;
         checks++;
         if (lat != 1) begin
            errors++;
            $display("FAIL single_latency[%0d]: got %0d, expected 1", r, lat);
         end
         tick();
         checks++;
         if ({busy, ack, gnt, i0, i1} !== 11'b0) begin
            errors++;
            $display("FAIL single_idle[%0d]: got %b, expected all zero", r,
                     {busy, ack, gnt, i0, i1});
         end
      end
   endtask

   task automatic test_round_robin();
      int lat, last, order[5];
      order = '{0, 1, 2, 3, 0};
      do_reset();
      a = 4'b1011; b = 4'b1101; req = 4'b1111;
      for (int t = 0; t < 5; t++) begin
         q0.push_back('{ack: 4'b0001 << order[t], res: a[order[t]] & b[order[t]]});
      end
      last = 0;
      for (int t = 0; t < 5; t++) begin
         wait_ack(1'b0, 6, lat);
         if (t > 0) begin
            checks++;
            if (cyc - last != 3) begin
               errors++;
               $display("FAIL rr_spacing[%0d]: got %0d cycles, expected 3", t, cyc - last);
            end
         end
         last = cyc;
      end
      req = '0;
      repeat (2) tick();
   endtask

   task automatic test_settle();
      int lat;
      for (int r = 0; r < 2; r++) begin
         a3 = (r == 0) ? 4'b0100 : 4'b1000;
         b3 = (r == 0) ? 4'b0000 : 4'b1000;
         req3 = a3;
         tick();
         checks++;
         if ({gnt3, busy3} !== {a3, 1'b1}) begin
            errors++;
            $display("FAIL settle_grant[%0d]: got gnt=%b busy=%b, expected %b 1", r, gnt3,
                     busy3, a3);
         end
         q3.push_back('{ack: a3, res: (r == 1)});
         wait_ack(1'b1, 8, lat);
         req3 = '0;
         checks++;
         if (lat != 3) begin
            errors++;
            $display("FAIL settle_latency[%0d]: got %0d, expected 3", r, lat);
         end
         repeat (2) tick();
      end
   endtask

   task automatic test_operand_change();
      int lat;
      req = 4'b0100; a = 4'b0100; b = 4'b0100;
      tick();
      q0.push_back('{ack: 4'b0100, res: 1'b1});
      a = '0; b = '0; req = '0;
      wait_ack(1'b0, 4, lat);
      checks++;
      if (lat != 1) begin
         errors++;
         $display("FAIL opchg_latency: got %0d, expected 1", lat);
      end
      repeat (2) tick();
   endtask

   task automatic test_starvation();
      int lat;
      do_reset();
      a = 4'b1001; b = 4'b1000; req = 4'b0001;
      tick();
      req = 4'b1001;
      q0.push_back('{ack: 4'b0001, res: 1'b0});
      q0.push_back('{ack: 4'b1000, res: 1'b1});
      q0.push_back('{ack: 4'b0001, res: 1'b0});
      for (int t = 0; t < 3; t++) begin
         wait_ack(1'b0, 6, lat);
      end
      req = '0;
      repeat (2) tick();
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_settle();
      test_operand_change();
      test_starvation();
      checks++;
      if (q0.size() + q3.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d entries left, expected 0",
                  q0.size() + q3.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
